symbol_counter: RTL and testbench

//  Front stage of the Huffman coding pipeline; feeds the sorting stage.
//  - Tallies the occurrences of symbols 1..6 over one frame of gray pixels.
//  - Packs the non-zero tallies into O1..O(num), with the matching symbol ids in
//    SYM1..SYM(num), then raises CNT_valid for the sorting stage.

---
 rtl/symbol_counter.sv | 174 +++++++++++++++++
 tb/tb_symbol_counter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/symbol_counter.sv
// Tallies gray-pixel symbols 1..6 over a frame, then packs the non-zero tallies
// for the sorting stage. Optional sticky illegal-pixel flag: define SYMCNT_ERR_EN.
module symbol_counter #(
  parameter int FRAME_LEN = 100,
  parameter int CW        = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          gray_valid,
  input  logic [7:0]    gray_data,
  input  logic          clear,
  output logic          CNT_valid,
  output logic [2:0]    num,
  output logic [CW-1:0] O1,
  output logic [CW-1:0] O2,
  output logic [CW-1:0] O3,
  output logic [CW-1:0] O4,
  output logic [CW-1:0] O5,
  output logic [CW-1:0] O6,
  output logic [2:0]    SYM1,
  output logic [2:0]    SYM2,
  output logic [2:0]    SYM3,
  output logic [2:0]    SYM4,
  output logic [2:0]    SYM5,
  output logic [2:0]    SYM6,
  output logic [1:0]    state_dbg
`ifdef SYMCNT_ERR_EN
  ,
  output logic          sym_err
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_PACK, ST_DONE} state_t;

  localparam logic [7:0] LAST_PIX = 8'(FRAME_LEN - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] tally_q [6];
  logic [CW-1:0] tally_d [6];
  logic [CW-1:0] o_q     [6];
  logic [CW-1:0] o_d     [6];
  logic [2:0]    sym_q   [6];
  logic [2:0]    sym_d   [6];
  logic [7:0]    pix_cnt_q, pix_cnt_d;
  logic [2:0]    scan_q, scan_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    num_q, num_d;
  logic          cnt_valid_q, cnt_valid_d;

  logic       accept, legal, last_pix, do_clear;
  logic [2:0] tidx;

  // Pixels are only taken while the frame is open; PACK/DONE drop them.
  assign accept   = gray_valid && ((state_q == ST_IDLE) || (state_q == ST_COUNT));
  assign legal    = (gray_data >= 8'd1) && (gray_data <= 8'd6);
  assign last_pix = accept && (pix_cnt_q == LAST_PIX);
  assign do_clear = (state_q == ST_DONE) && clear;
  assign tidx     = gray_data[2:0] - 3'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (last_pix) state_d = ST_PACK;
                else if (accept) state_d = ST_COUNT;
      ST_COUNT: if (last_pix) state_d = ST_PACK;
      ST_PACK:  if (scan_q == 3'd5) state_d = ST_DONE;
      ST_DONE:  if (clear) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tally_d     = tally_q;
    o_d         = o_q;
    sym_d       = sym_q;
    pix_cnt_d   = pix_cnt_q;
    scan_d      = scan_q;
    ptr_d       = ptr_q;
    num_d       = num_q;
    // Registered so it drops on the same edge that leaves DONE.
    cnt_valid_d = (state_q == ST_DONE) && !clear;
    if (do_clear) begin
      for (int i = 0; i < 6; i++) begin
        tally_d[i] = '0;
        o_d[i]     = '0;
        sym_d[i]   = '0;
      end
      pix_cnt_d = '0;
      scan_d    = '0;
      ptr_d     = '0;
      num_d     = '0;
    end else begin
      if (accept) begin
        pix_cnt_d = pix_cnt_q + 8'd1;
        if (legal && (tally_q[tidx] != '1))
          tally_d[tidx] = tally_q[tidx] + CW'(1);
      end
      if (state_q == ST_PACK) begin
        if (tally_q[scan_q] != '0) begin
          o_d[ptr_q]   = tally_q[scan_q];
          sym_d[ptr_q] = scan_q + 3'd1;
          ptr_d        = ptr_q + 3'd1;
        end
        scan_d = scan_q + 3'd1;
        if (scan_q == 3'd5) num_d = ptr_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) begin
        tally_q[i] <= '0;
        o_q[i]     <= '0;
        sym_q[i]   <= '0;
      end
      pix_cnt_q   <= '0;
      scan_q      <= '0;
      ptr_q       <= '0;
      num_q       <= '0;
      cnt_valid_q <= 1'b0;
    end else begin
      tally_q     <= tally_d;
      o_q         <= o_d;
      sym_q       <= sym_d;
      pix_cnt_q   <= pix_cnt_d;
      scan_q      <= scan_d;
      ptr_q       <= ptr_d;
      num_q       <= num_d;
      cnt_valid_q <= cnt_valid_d;
    end
  end

`ifdef SYMCNT_ERR_EN
  logic sym_err_q, sym_err_d;

  always_comb begin
    sym_err_d = sym_err_q;
    if (do_clear)               sym_err_d = 1'b0;
    else if (accept && !legal)  sym_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sym_err_q <= 1'b0;
    else        sym_err_q <= sym_err_d;
  end

  assign sym_err = sym_err_q;
`endif

  always_comb begin
    CNT_valid = cnt_valid_q;
    num       = num_q;
    O1        = o_q[0];
    O2        = o_q[1];
    O3        = o_q[2];
    O4        = o_q[3];
    O5        = o_q[4];
    O6        = o_q[5];
    SYM1      = sym_q[0];
    SYM2      = sym_q[1];
    SYM3      = sym_q[2];
    SYM4      = sym_q[3];
    SYM5      = sym_q[4];
    SYM6      = sym_q[5];
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_symbol_counter.sv
// Self-checking bench for symbol_counter: a 100-pixel instance for most frames
// and a 255-pixel instance for the maximum-length frame.
module tb_symbol_counter;

  localparam int CW = 8;
  localparam int W  = 3 + 6 * CW + 6 * 3;

  logic clk, reset;

  logic          gray_valid, clear, CNT_valid;
  logic [7:0]    gray_data;
  logic [2:0]    num;
  logic [CW-1:0] O1, O2, O3, O4, O5, O6;
  logic [2:0]    SYM1, SYM2, SYM3, SYM4, SYM5, SYM6;
  logic [1:0]    state_dbg;

  logic          gray_valid_b, clear_b, CNT_valid_b;
  logic [7:0]    gray_data_b;
  logic [2:0]    num_b;
  logic [CW-1:0] O1_b, O2_b, O3_b, O4_b, O5_b, O6_b;
  logic [2:0]    SYM1_b, SYM2_b, SYM3_b, SYM4_b, SYM5_b, SYM6_b;
  logic [1:0]    state_dbg_b;
`ifdef SYMCNT_ERR_EN
  logic sym_err, sym_err_b;
`endif

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   frame_px[$];

  symbol_counter #(.FRAME_LEN(100), .CW(CW)) u_dut (
    .clk(clk), .reset(reset), .gray_valid(gray_valid), .gray_data(gray_data),
    .clear(clear), .CNT_valid(CNT_valid), .num(num),
    .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6),
    .SYM1(SYM1), .SYM2(SYM2), .SYM3(SYM3), .SYM4(SYM4), .SYM5(SYM5), .SYM6(SYM6),
    .state_dbg(state_dbg)
`ifdef SYMCNT_ERR_EN
    , .sym_err(sym_err)
`endif
  );

  symbol_counter #(.FRAME_LEN(255), .CW(CW)) u_dut255 (
    .clk(clk), .reset(reset), .gray_valid(gray_valid_b), .gray_data(gray_data_b),
    .clear(clear_b), .CNT_valid(CNT_valid_b), .num(num_b),
    .O1(O1_b), .O2(O2_b), .O3(O3_b), .O4(O4_b), .O5(O5_b), .O6(O6_b),
    .SYM1(SYM1_b), .SYM2(SYM2_b), .SYM3(SYM3_b), .SYM4(SYM4_b), .SYM5(SYM5_b),
    .SYM6(SYM6_b), .state_dbg(state_dbg_b)
`ifdef SYMCNT_ERR_EN
    , .sym_err(sym_err_b)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1);
  end

  function automatic logic [W-1:0] act_a();
    return {num, O1, O2, O3, O4, O5, O6, SYM1, SYM2, SYM3, SYM4, SYM5, SYM6};
  endfunction

  function automatic logic [W-1:0] act_b();
    return {num_b, O1_b, O2_b, O3_b, O4_b, O5_b, O6_b,
            SYM1_b, SYM2_b, SYM3_b, SYM4_b, SYM5_b, SYM6_b};
  endfunction

  // Reference packing: ascending symbol order, zero tallies skipped.
  function automatic logic [W-1:0] model_pack(input int t[6]);
    logic [CW-1:0] o[6];
    logic [2:0]    s[6];
    int p;
    p = 0;
    for (int i = 0; i < 6; i++) begin
      o[i] = '0;
      s[i] = '0;
    end
    for (int i = 0; i < 6; i++) begin
      if (t[i] != 0) begin
        o[p] = CW'(t[i]);
        s[p] = 3'(i + 1);
        p++;
      end
    end
    return {3'(p), o[0], o[1], o[2], o[3], o[4], o[5], s[0], s[1], s[2], s[3], s[4], s[5]};
  endfunction

  // Driver: sends frame_px to the 100-pixel instance and pushes the expected result.
  task automatic send_frame();
    int t[6];
    for (int i = 0; i < 6; i++) t[i] = 0;
    foreach (frame_px[k]) begin
      if (frame_px[k] >= 1 && frame_px[k] <= 6 && t[frame_px[k] - 1] < (1 << CW) - 1)
        t[frame_px[k] - 1]++;
      gray_valid = 1'b1;
      gray_data  = frame_px[k];
      @(posedge clk); #1;
    end
    gray_valid = 1'b0;
    gray_data  = 8'd0;
    exp_q.push_back(model_pack(t));
  endtask

  // Bounded wait for CNT_valid after the last pixel; lat = -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (CNT_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; gray_valid = 1'b0; gray_data = 8'd0; clear = 1'b0;
    gray_valid_b = 1'b0; gray_data_b = 8'd0; clear_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (CNT_valid !== 1'b0) begin errors++; $display("FAIL reset_cnt_valid: got %b required 0", CNT_valid); end
    checks++;
    if (act_a() !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", act_a()); end
    checks++;
    if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    checks++;
    if (act_b() !== '0 || CNT_valid_b !== 1'b0) begin
      errors++; $display("FAIL reset_outputs_255: got %h/%b required 0/0", act_b(), CNT_valid_b);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string name);
    int lat;
    logic [W-1:0] exp_v;
    wait_done(lat);
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL %s_latency: got %0d required 7", name, lat); end
    exp_v = exp_q.pop_front();
    checks++;
    if (act_a() !== exp_v) begin errors++; $display("FAIL %s_result: got %h required %h", name, act_a(), exp_v); end
  endtask

  task automatic test_even();
    int c[5];
    int v;
    for (int i = 0; i < 5; i++) c[i] = 0;
    frame_px.delete();
    for (int i = 0; i < 100; i++) begin
      do v = $urandom_range(1, 5); while (c[v - 1] >= 20);
      c[v - 1]++;
      frame_px.push_back(8'(v));
    end
    send_frame();
    check_frame("even_five");
    checks++;
    if (num !== 3'd5 || O1 !== 8'd20 || SYM5 !== 3'd5 || O6 !== 8'd0 || SYM6 !== 3'd0) begin
      errors++; $display("FAIL even_five_fields: got num=%0d O1=%0d SYM5=%0d O6=%0d SYM6=%0d required 5 20 5 0 0",
                         num, O1, SYM5, O6, SYM6);
    end
    pulse_clear();
  endtask

  task automatic test_two_sym();
    frame_px.delete();
    for (int i = 0; i < 60; i++) frame_px.push_back(8'd2);
    for (int i = 0; i < 40; i++) frame_px.insert($urandom_range(0, frame_px.size()), 8'd6);
    send_frame();
    check_frame("two_sym");
    checks++;
    if (num !== 3'd2 || O1 !== 8'd60 || SYM1 !== 3'd2 || O2 !== 8'd40 || SYM2 !== 3'd6 || O3 !== 8'd0) begin
      errors++; $display("FAIL two_sym_fields: got num=%0d O1=%0d SYM1=%0d O2=%0d SYM2=%0d O3=%0d required 2 60 2 40 6 0",
                         num, O1, SYM1, O2, SYM2, O3);
    end
    pulse_clear();
  endtask

  task automatic test_frame255();
    int lat;
    logic [W-1:0] exp_v;
    exp_v = {3'd1, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    for (int i = 0; i < 255; i++) begin
      gray_valid_b = 1'b1; gray_data_b = 8'd3;
      @(posedge clk); #1;
    end
    gray_valid_b = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (CNT_valid_b === 1'b1) begin lat = c; break; end
    end
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL frame255_latency: got %0d required 7", lat); end
    checks++;
    if (act_b() !== exp_v) begin errors++; $display("FAIL frame255_result: got %h required %h", act_b(), exp_v); end
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (CNT_valid_b !== 1'b1) begin errors++; $display("FAIL frame255_hold: got %b required 1", CNT_valid_b); end
    clear_b = 1'b1;
    @(posedge clk); #1;
    clear_b = 1'b0;
    checks++;
    if (act_b() !== '0 || CNT_valid_b !== 1'b0 || state_dbg_b !== 2'd0) begin
      errors++; $display("FAIL frame255_clear: got %h/%b/%0d required 0/0/0", act_b(), CNT_valid_b, state_dbg_b);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 50; i++) begin
      gray_valid = 1'b1; gray_data = 8'd1;
      @(posedge clk); #1;
    end
    gray_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (state_dbg !== 2'd0 || act_a() !== '0) begin
      errors++; $display("FAIL reset_mid_state: got %0d/%h required 0/0", state_dbg, act_a());
    end
    @(posedge clk); #1;
    reset = 1'b1;
    frame_px.delete();
    for (int i = 0; i < 100; i++) frame_px.push_back(8'd4);
    send_frame();
    check_frame("reset_mid");
    pulse_clear();
  endtask

  task automatic test_illegal();
`ifdef SYMCNT_ERR_EN
    checks++;
    if (sym_err !== 1'b0) begin errors++; $display("FAIL sym_err_start: got %b required 0", sym_err); end
`endif
    frame_px.delete();
    for (int i = 0; i < 90; i++) frame_px.push_back(8'd1);
    for (int i = 0; i < 10; i++) frame_px.insert($urandom_range(0, frame_px.size()), 8'd9);
    send_frame();
    check_frame("illegal_mix");
`ifdef SYMCNT_ERR_EN
    checks++;
    if (sym_err !== 1'b1) begin errors++; $display("FAIL sym_err_set: got %b required 1", sym_err); end
`endif
    pulse_clear();
`ifdef SYMCNT_ERR_EN
    checks++;
    if (sym_err !== 1'b0) begin errors++; $display("FAIL sym_err_clear: got %b required 0", sym_err); end
`endif
  endtask

  task automatic test_all_illegal();
    frame_px.delete();
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 0) frame_px.push_back(8'd0);
      else frame_px.push_back(8'($urandom_range(7, 255)));
    end
    send_frame();
    check_frame("all_illegal");
    pulse_clear();
  endtask

  task automatic test_random();
    frame_px.delete();
    for (int i = 0; i < 100; i++) frame_px.push_back(8'($urandom_range(0, 8)));
    send_frame();
    check_frame("random_mix");
    pulse_clear();
  endtask

  task automatic test_done_hold();
    logic [W-1:0] held;
    frame_px.delete();
    for (int i = 0; i < 100; i++) frame_px.push_back(8'($urandom_range(1, 6)));
    send_frame();
    check_frame("hold_frame");
    held = act_a();
    for (int i = 0; i < 5; i++) begin
      gray_valid = 1'b1; gray_data = 8'($urandom_range(1, 6));
      @(posedge clk); #1;
      checks++;
      if (act_a() !== held || CNT_valid !== 1'b1) begin
        errors++; $display("FAIL done_hold_%0d: got %h/%b required %h/1", i, act_a(), CNT_valid, held);
      end
    end
    gray_data = 8'd1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    gray_valid = 1'b0;
    checks++;
    if (state_dbg !== 2'd0 || CNT_valid !== 1'b0 || act_a() !== '0) begin
      errors++; $display("FAIL clear_to_idle: got state=%0d valid=%b out=%h required 0/0/0",
                         state_dbg, CNT_valid, act_a());
    end
    // A pixel taken on the clear edge would shorten this frame and add a symbol-1 tally.
    frame_px.delete();
    for (int i = 0; i < 100; i++) frame_px.push_back(8'd5);
    send_frame();
    check_frame("after_clear");
    pulse_clear();
  endtask

  initial begin
    test_reset();
    test_even();
    test_two_sym();
    test_frame255();
    test_reset_mid();
    test_illegal();
    test_all_illegal();
    test_random();
    test_done_hold();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
